// File: rtl/brisc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : brisc_pkg
// Brief    : Shared core-wide width constant and pipeline handshake state types.
// Revision : 1.0 - initial release
// ============================================================================
package brisc_pkg;

    localparam int XLEN = 32;

    // Occupancy of a skid buffer: FULL2 means both main and skid entries hold data.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_FULL  = 2'd1,
        SKID_FULL2 = 2'd2
    } skid_state_e;

endpackage
`default_nettype wire

// File: rtl/ff.sv
`default_nettype none
// ============================================================================
// Module   : ff
// Brief    : Enabled D flip-flop bank with synchronous active-high reset value.
// Revision : 1.0 - initial release
// ============================================================================
module ff #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            o_q <= RESET_VALUE;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : skid_buffer
// Brief    : Two-entry elastic pipeline register; in_ready comes from a flop only.
// Revision : 1.0 - initial release
// ============================================================================
module skid_buffer
    import brisc_pkg::*;
#(
    parameter int               WIDTH       = XLEN,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      r_state;
    logic             r_out_valid;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_main_load;
    logic             w_skid_load;
    logic [WIDTH-1:0] w_main_d;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // Flush suppresses every data load so the registers simply keep stale contents.
    always_comb begin
        w_main_load = 1'b0;
        w_skid_load = 1'b0;
        w_main_d    = in_data;
        if (!flush) begin
            case (r_state)
                SKID_EMPTY: begin
                    w_main_load = w_in_fire;
                end
                SKID_FULL: begin
                    w_main_load = w_in_fire & w_out_fire;
                    w_skid_load = w_in_fire & ~w_out_fire;
                end
                SKID_FULL2: begin
                    w_main_load = w_out_fire;
                    w_main_d    = r_skid_data;
                end
                default: begin
                    w_main_load = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state     <= SKID_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_in_fire) begin
                        r_state     <= SKID_FULL;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                SKID_FULL: begin
                    if (w_in_fire && !w_out_fire) begin
                        r_state     <= SKID_FULL2;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b0;
                    end else if (!w_in_fire && w_out_fire) begin
                        r_state     <= SKID_EMPTY;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                SKID_FULL2: begin
                    if (w_out_fire) begin
                        r_state     <= SKID_FULL;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= SKID_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    ff #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main_reg (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_main_load),
        .i_d   (w_main_d),
        .o_q   (r_main_data)
    );

    ff #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid_reg (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_skid_load),
        .i_d   (in_data),
        .o_q   (r_skid_data)
    );

    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;
    assign out_data  = r_main_data;

endmodule
`default_nettype wire

// File: doc/skid_buffer.md
Name: skid_buffer

Overview:
- Elastic pipeline-stage register with a valid/ready handshake on both sides.
- Sits between core pipeline stages, e.g. fetch->decode or in front of the multi-cycle mul/div unit, and feeds the plain flip-flop/delay-line registers downstream.
- Decouples the upstream ready path from the downstream ready path: in_ready is driven purely from a register.
- Sustains one transfer per cycle with no bubbles; adds a second "skid" entry that absorbs the in-flight beat when downstream stalls.

Parameters:
- WIDTH, XLEN (32): payload width in bits.
- RESET_VALUE, '0: value loaded into both data registers on reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; discards all buffered entries.
- in_valid  input  1  upstream has a valid payload.
- in_ready  output  1  buffer can accept a payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  buffer presents a valid payload.
- out_ready  input  1  downstream accepts the payload this cycle.
- out_data  output  WIDTH  payload presented downstream.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Handshake definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Source rules: once asserted, a source holds valid and data stable until it fires. The block obeys this on its out side.
- Storage: main register (data, valid) drives out_data/out_valid directly. The skid register holds one overflow entry.
- States, encoded as skid_state_e:
  - EMPTY: main invalid, skid invalid.
  - FULL: main valid, skid invalid.
  - SKID: main valid, skid valid.
- Outputs per state:
  - out_valid = 1 in FULL and SKID.
  - in_ready = 1 in EMPTY and FULL, 0 in SKID.
  - Both are functions of state only, with no combinational path from out_ready or in_valid.
- Transitions, with reset and flush both low:
  - EMPTY: in_fire -> FULL, main <= in_data. Otherwise stay.
  - FULL, in_fire & out_fire -> FULL, main <= in_data.
  - FULL, in_fire & !out_fire -> SKID, skid <= in_data.
  - FULL, !in_fire & out_fire -> EMPTY.
  - FULL, neither fires -> stay.
  - SKID: out_fire -> FULL, main <= skid data. Otherwise hold; in_fire is impossible because in_ready=0.
- Latency and throughput:
  - Latency in_fire -> out_valid is 1 cycle.
  - Throughput is 1 beat/cycle while out_ready=1.
  - Ordering is strictly FIFO; no beat is dropped or duplicated.
- Flush:
  - Next state is EMPTY regardless of current state and same-cycle handshakes.
  - A beat presented with in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as delivered downstream, since the consumer sampled it.
  - Data registers keep their old contents (don't-care, never observable while out_valid=0).
- Reset:
  - Highest priority, above flush.
  - After the reset edge: state EMPTY, out_valid=0, in_ready=1, out_data=RESET_VALUE, skid data=RESET_VALUE.
  - Reset mid-transfer drops all held beats.
- Boundary cases:
  - SKID with out_ready held low: holds indefinitely, in_ready stays 0, and the upstream beat is not lost.
  - Back-to-back stall/release: never more than 2 beats stored.
  - out_data is stable while out_valid=1 and out_ready=0.

Decomposition:
- brisc_pkg gets the typedef enum logic [1:0] skid_state_e {SKID_EMPTY, SKID_FULL, SKID_FULL2}.
- Payload width defaults to the existing XLEN.
- Main and skid data registers are each one instance of the existing ff module (WIDTH, RESET_VALUE, enable = load strobe). No new sub-module is needed.
- The FSM and load-strobe logic live in skid_buffer.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_data=0 after the last reset edge.
- Streaming: out_ready=1 constant, send 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 appear one cycle later, no bubbles, in_ready stays 1.
- Stall/skid: send 0xA then 0xB with out_ready=0 from the cycle 0xA lands -> state SKID, in_ready=0, out_data holds 0xA. Raise out_ready -> 0xA then 0xB delivered in order, in_ready returns to 1 one cycle after the first out_fire.
- Long stall: hold out_ready=0 for 10 cycles in SKID with upstream holding 0xC -> no change. On release, 0xA, 0xB, 0xC emerge in order.
- Flush: in SKID (0xA, 0xB) assert flush with in_valid=1 and in_data=0xD -> next cycle out_valid=0, in_ready=1, and 0xD never appears downstream.
- Reset vs flush: in FULL assert reset and flush together -> EMPTY with out_data=RESET_VALUE. Random valid/ready scoreboard over 10k cycles -> zero ordering, loss or duplication errors.
